// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game fruit/event logic.
package snake_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SPAWN = 3'd1,
      ST_PLAY  = 3'd2,
      ST_APPLY = 3'd3,
      ST_OVER  = 3'd4
   } state_t;

   localparam int CELL  = 16;
   localparam int COLS  = 40;
   localparam int ROWS  = 30;
   localparam int BLANK = 2;   // PLAY cycles during which the collision checker output is stale

   localparam logic [1:0] FT_NONE   = 2'b00;
   localparam logic [1:0] FT_GROW   = 2'b01;
   localparam logic [1:0] FT_SHRINK = 2'b10;
   localparam logic [1:0] FT_LIFE   = 2'b11;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   // Candidate fruit placement produced by the LFSR decoder
   typedef struct packed {
      logic [9:0] x;
      logic [8:0] y;
      logic [1:0] ftype;
      logic       in_range;
   } fruit_cand_t;

   // Fibonacci LFSR step, taps 16,14,13,11
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

endpackage

// File: rtl/fruit_lfsr.sv
// Pseudo-random fruit placement source: 16-bit LFSR plus grid-cell decode.
import snake_pkg::*;

module fruit_lfsr (
   input  logic        clk,
   input  logic        reset,
   input  logic        step,
   output fruit_cand_t cand
);

   logic [15:0] lfsr;
   logic [5:0]  col;
   logic [4:0]  row;

   // LFSR advances only while the controller is searching for a spot
   always_ff @(posedge clk or posedge reset) begin
      if (reset)     lfsr <= LFSR_SEED;
      else if (step) lfsr <= lfsr_next(lfsr);
   end

   // Decode the current LFSR value into a pixel-aligned candidate
   always_comb begin
      col            = lfsr[5:0];
      row            = lfsr[12:8];
      cand.x         = 10'(col) << $clog2(CELL);
      cand.y         = 9'(row) << $clog2(CELL);
      cand.ftype     = (lfsr[15:14] == FT_NONE) ? FT_GROW : lfsr[15:14];
      cand.in_range  = (col < 6'(COLS)) && (row < 5'(ROWS));
   end

endmodule

// File: rtl/fruit_event_controller.sv
// Fruit placement and game-event controller (length, lives, score).
// Optional build macro FRUIT_TIMEOUT_EN: relocates an uneaten fruit after
// TIMEOUT_TICKS game ticks in PLAY.
import snake_pkg::*;

module fruit_event_controller #(
   parameter int INIT_LEN      = 3,
   parameter int MIN_LEN       = 3,
   parameter int MAX_LEN       = 64,
   parameter int INIT_LIVES    = 3,
   parameter int MAX_LIVES     = 7,
   parameter int TIMEOUT_TICKS = 200
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       tick,
   input  logic       hazard,
   input  logic       collision,
   input  logic [1:0] fruit_collision_type,
   input  logic [9:0] snake_x,
   input  logic [8:0] snake_y,
   output logic [9:0] fruit_x,
   output logic [8:0] fruit_y,
   output logic [1:0] fruit_type,
   output logic       fruit_valid,
   output logic [6:0] snake_len,
   output logic [2:0] lives,
   output logic [15:0] score,
   output logic       game_over,
   output logic       grow_pulse,
   output logic       shrink_pulse
);

   state_t       state, nstate;
   fruit_cand_t  cand;
   logic         accept, col_hit, timeout;
   logic [1:0]   ltype, ltype_d;
   logic [BLANK:0] vld_pipe;

   logic [9:0]  fruit_x_d;
   logic [8:0]  fruit_y_d;
   logic [1:0]  fruit_type_d;
   logic        fruit_valid_d, game_over_d, grow_d, shrink_d;
   logic [6:0]  len_d;
   logic [2:0]  lives_d;
   logic [15:0] score_d;

   fruit_lfsr u_lfsr (
      .clk   (clk),
      .reset (reset),
      .step  (state == ST_SPAWN),
      .cand  (cand)
   );

   assign accept  = cand.in_range && !((cand.x == snake_x) && (cand.y == snake_y));
   assign col_hit = collision && vld_pipe[BLANK] && (fruit_collision_type != FT_NONE);

`ifdef FRUIT_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_TICKS + 1);
   logic [TW-1:0] tcnt;

   assign timeout = tick && (tcnt == TW'(TIMEOUT_TICKS - 1));

   // Tick counter lives only in PLAY; restarts from zero on every PLAY entry
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                tcnt <= '0;
      else if (state != ST_PLAY) tcnt <= '0;
      else if (tick)             tcnt <= timeout ? '0 : tcnt + 1'b1;
   end
`else
   logic unused_cfg;
   assign timeout    = 1'b0;
   assign unused_cfg = tick ^ (TIMEOUT_TICKS != 0);
`endif

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= nstate;
   end

   // Next-state: hazard beats collision, collision beats timeout
   always_comb begin
      nstate = state;
      case (state)
         ST_IDLE, ST_OVER: if (start) nstate = ST_SPAWN;
         ST_SPAWN:         if (accept) nstate = ST_PLAY;
         ST_PLAY: begin
            if (hazard)       nstate = (lives <= 3'd1) ? ST_OVER : ST_PLAY;
            else if (col_hit) nstate = ST_APPLY;
            else if (timeout) nstate = ST_SPAWN;
         end
         ST_APPLY: begin
            if ((ltype == FT_SHRINK) && (snake_len <= 7'(MIN_LEN)) && (lives <= 3'd1))
               nstate = ST_OVER;
            else
               nstate = ST_SPAWN;
         end
         default: nstate = ST_IDLE;
      endcase
   end

   // Next values of the registered outputs
   always_comb begin
      fruit_x_d     = fruit_x;
      fruit_y_d     = fruit_y;
      fruit_type_d  = fruit_type;
      fruit_valid_d = fruit_valid;
      len_d         = snake_len;
      lives_d       = lives;
      score_d       = score;
      game_over_d   = game_over;
      ltype_d       = ltype;
      grow_d        = 1'b0;
      shrink_d      = 1'b0;
      case (state)
         ST_IDLE, ST_OVER: begin
            if (start) begin
               len_d         = 7'(INIT_LEN);
               lives_d       = 3'(INIT_LIVES);
               score_d       = '0;
               game_over_d   = 1'b0;
               fruit_valid_d = 1'b0;
            end
         end
         ST_SPAWN: begin
            fruit_valid_d = 1'b0;
            if (accept) begin
               fruit_x_d     = cand.x;
               fruit_y_d     = cand.y;
               fruit_type_d  = cand.ftype;
               fruit_valid_d = 1'b1;
            end
         end
         ST_PLAY: begin
            if (hazard) begin
               lives_d = (lives == 3'd0) ? 3'd0 : lives - 3'd1;
               len_d   = 7'(INIT_LEN);
               if (lives <= 3'd1) begin
                  game_over_d   = 1'b1;
                  fruit_valid_d = 1'b0;
               end
            end else if (col_hit) begin
               ltype_d = fruit_collision_type;
            end else if (timeout) begin
               fruit_valid_d = 1'b0;
            end
         end
         ST_APPLY: begin
            case (ltype)
               FT_GROW: begin
                  len_d   = (snake_len >= 7'(MAX_LEN)) ? 7'(MAX_LEN) : snake_len + 7'd1;
                  score_d = (score == 16'hFFFF) ? 16'hFFFF : score + 16'd1;
                  grow_d  = 1'b1;
               end
               FT_SHRINK: begin
                  if (snake_len > 7'(MIN_LEN)) begin
                     len_d    = snake_len - 7'd1;
                     shrink_d = 1'b1;
                  end else begin
                     lives_d = (lives == 3'd0) ? 3'd0 : lives - 3'd1;
                  end
               end
               FT_LIFE: lives_d = (lives >= 3'(MAX_LIVES)) ? 3'(MAX_LIVES) : lives + 3'd1;
               default: ;
            endcase
            fruit_valid_d = 1'b0;
            if (nstate == ST_OVER) game_over_d = 1'b1;
         end
         default: ;
      endcase
   end

   // Output and datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fruit_x      <= '0;
         fruit_y      <= '0;
         fruit_type   <= '0;
         fruit_valid  <= 1'b0;
         snake_len    <= '0;
         lives        <= '0;
         score        <= '0;
         game_over    <= 1'b0;
         grow_pulse   <= 1'b0;
         shrink_pulse <= 1'b0;
         ltype        <= FT_NONE;
      end else begin
         fruit_x      <= fruit_x_d;
         fruit_y      <= fruit_y_d;
         fruit_type   <= fruit_type_d;
         fruit_valid  <= fruit_valid_d;
         snake_len    <= len_d;
         lives        <= lives_d;
         score        <= score_d;
         game_over    <= game_over_d;
         grow_pulse   <= grow_d;
         shrink_pulse <= shrink_d;
         ltype        <= ltype_d;
      end
   end

   // Collision blanking: a 1 walks up the pipe once PLAY is entered; arms at the top
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                 vld_pipe <= '0;
      else if (state != ST_PLAY) vld_pipe <= (BLANK+1)'(1);
      else                       vld_pipe <= {vld_pipe[BLANK-1:0], 1'b1};
   end

endmodule

// File: tb/tb_fruit_event_controller.sv
// Directed bench for fruit_event_controller; builds with or without FRUIT_TIMEOUT_EN.
import snake_pkg::*;

module tb_fruit_event_controller;

   logic        clk = 1'b0;
   logic        reset, start, tick, hazard, collision;
   logic [1:0]  fct;
   logic [9:0]  snake_x, fruit_x;
   logic [8:0]  snake_y, fruit_y;
   logic [1:0]  fruit_type;
   logic        fruit_valid, game_over, grow_pulse, shrink_pulse;
   logic [6:0]  snake_len;
   logic [2:0]  lives;
   logic [15:0] score;

   int vectors = 0;
   int errs    = 0;
   logic [9:0] keep_x;
   logic [8:0] keep_y;

   always #5 clk = ~clk;

   fruit_event_controller #(.TIMEOUT_TICKS(4)) dut (
      .clk(clk), .reset(reset), .start(start), .tick(tick), .hazard(hazard),
      .collision(collision), .fruit_collision_type(fct),
      .snake_x(snake_x), .snake_y(snake_y),
      .fruit_x(fruit_x), .fruit_y(fruit_y), .fruit_type(fruit_type),
      .fruit_valid(fruit_valid), .snake_len(snake_len), .lives(lives),
      .score(score), .game_over(game_over),
      .grow_pulse(grow_pulse), .shrink_pulse(shrink_pulse)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Wait (bounded) for a fruit to be placed, then check placement rules
   task automatic wait_valid(input string tag);
      int n;
      n = 0;
      while (!fruit_valid && n < 200) begin
         step();
         n++;
      end
      chk({tag, "_valid"}, 32'(fruit_valid), 32'd1);
      chk({tag, "_xrange"}, 32'(fruit_x < 10'd640 && fruit_x[3:0] == 4'd0), 32'd1);
      chk({tag, "_yrange"}, 32'(fruit_y < 9'd480 && fruit_y[3:0] == 4'd0), 32'd1);
      chk({tag, "_nothead"}, 32'(fruit_x == snake_x && fruit_y == snake_y), 32'd0);
   endtask

   // From PLAY entry: sit out blanking, hit a fruit of type t, leave APPLY
   task automatic eat(input logic [1:0] t);
      step();
      step();
      collision = 1'b1;
      fct = t;
      step();
      collision = 1'b0;
      fct = FT_NONE;
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; start = 0; tick = 0; hazard = 0; collision = 0; fct = 0;
      snake_x = 10'd0; snake_y = 9'd0;
      step(); step();
      reset = 1'b0;
      step();
      chk("rst_state", 32'(dut.state), 32'(ST_IDLE));
      chk("rst_len", 32'(snake_len), 32'd0);
      chk("rst_lives", 32'(lives), 32'd0);
      chk("rst_score", 32'(score), 32'd0);
      chk("rst_fv", 32'(fruit_valid), 32'd0);
      chk("rst_fx", 32'(fruit_x), 32'd0);

      // hazard/tick in IDLE ignored
      hazard = 1'b1; tick = 1'b1;
      step();
      hazard = 1'b0; tick = 1'b0;
      chk("idle_haz", 32'(dut.state), 32'(ST_IDLE));

      // head on the seed's candidate (528,192): first SPAWN cycle must retry
      snake_x = 10'd528; snake_y = 9'd192;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("st1_len", 32'(snake_len), 32'd3);
      chk("st1_lives", 32'(lives), 32'd3);
      step();
      chk("spawn_retry_fv", 32'(fruit_valid), 32'd0);
      chk("spawn_retry_st", 32'(dut.state), 32'(ST_SPAWN));
      reset = 1'b1;
      step();
      chk("midspawn_state", 32'(dut.state), 32'(ST_IDLE));
      chk("midspawn_lfsr", 32'(dut.u_lfsr.lfsr), 32'h0000ACE1);
      chk("midspawn_len", 32'(snake_len), 32'd0);
      chk("midspawn_lives", 32'(lives), 32'd0);
      reset = 1'b0;
      snake_x = 10'd0; snake_y = 9'd0;
      step();

      // new game: seed candidate col 33 row 12 type 10
      start = 1'b1;
      step();
      start = 1'b0;
      chk("start_len", 32'(snake_len), 32'd3);
      chk("start_lives", 32'(lives), 32'd3);
      chk("start_go", 32'(game_over), 32'd0);
      chk("start_fv", 32'(fruit_valid), 32'd0);
      wait_valid("f0");
      chk("f0_x", 32'(fruit_x), 32'd528);
      chk("f0_y", 32'(fruit_y), 32'd192);
      chk("f0_t", 32'(fruit_type), 32'd2);

      // checker echo during the two blanked cycles
      collision = 1'b1; fct = FT_GROW;
      step(); step();
      collision = 1'b0;
      chk("blank_state", 32'(dut.state), 32'(ST_PLAY));
      chk("blank_len", 32'(snake_len), 32'd3);
      chk("blank_score", 32'(score), 32'd0);
      // type 00 ignored once armed
      collision = 1'b1; fct = FT_NONE;
      step();
      collision = 1'b0;
      chk("t00_state", 32'(dut.state), 32'(ST_PLAY));

      // grow: 3 -> 4, score 1, single pulse, next fruit from 16'h59C3
      collision = 1'b1; fct = FT_GROW;
      step();
      collision = 1'b0; fct = FT_NONE;
      chk("apply_state", 32'(dut.state), 32'(ST_APPLY));
      step();
      chk("grow_len", 32'(snake_len), 32'd4);
      chk("grow_score", 32'(score), 32'd1);
      chk("grow_pulse", 32'(grow_pulse), 32'd1);
      chk("grow_fv", 32'(fruit_valid), 32'd0);
      wait_valid("f1");
      chk("grow_pulse_off", 32'(grow_pulse), 32'd0);
      chk("f1_x", 32'(fruit_x), 32'd48);
      chk("f1_y", 32'(fruit_y), 32'd400);
      chk("f1_t", 32'(fruit_type), 32'd1);

      // shrink at len 4 -> 3 with pulse; next fruit from 16'hB387
      eat(FT_SHRINK);
      chk("shr_len", 32'(snake_len), 32'd3);
      chk("shr_pulse", 32'(shrink_pulse), 32'd1);
      chk("shr_lives", 32'(lives), 32'd3);
      wait_valid("f2");
      chk("f2_x", 32'(fruit_x), 32'd112);
      chk("f2_y", 32'(fruit_y), 32'd304);

      // shrink at MIN_LEN costs a life instead
      eat(FT_SHRINK);
      chk("shrmin_len", 32'(snake_len), 32'd3);
      chk("shrmin_pulse", 32'(shrink_pulse), 32'd0);
      chk("shrmin_lives", 32'(lives), 32'd2);
      wait_valid("f3");
      chk("f3_x", 32'(fruit_x), 32'd240);
      chk("f3_y", 32'(fruit_y), 32'd112);

      // extra lives, saturating at 7
      for (int i = 0; i < 6; i++) begin
         eat(FT_LIFE);
         chk("life_lives", 32'(lives), (i + 3 > 7) ? 32'd7 : 32'(i + 3));
         wait_valid("fl");
      end

      // grow once so the hazard length reload is visible
      eat(FT_GROW);
      chk("g2_len", 32'(snake_len), 32'd4);
      chk("g2_score", 32'(score), 32'd2);
      wait_valid("fg");

      keep_x = fruit_x; keep_y = fruit_y;
      hazard = 1'b1;
      step();
      hazard = 1'b0;
      chk("haz_lives", 32'(lives), 32'd6);
      chk("haz_len", 32'(snake_len), 32'd3);
      chk("haz_state", 32'(dut.state), 32'(ST_PLAY));
      chk("haz_fx", 32'(fruit_x), 32'(keep_x));
      chk("haz_fv", 32'(fruit_valid), 32'd1);

`ifdef FRUIT_TIMEOUT_EN
      tick = 1'b1;
      step(); step(); step();
      chk("to3_state", 32'(dut.state), 32'(ST_PLAY));
      step();
      tick = 1'b0;
      chk("to4_state", 32'(dut.state), 32'(ST_SPAWN));
      chk("to4_fv", 32'(fruit_valid), 32'd0);
      chk("to4_score", 32'(score), 32'd2);
      chk("to4_len", 32'(snake_len), 32'd3);
      wait_valid("fto");
`else
      tick = 1'b1;
      for (int i = 0; i < 300; i++) step();
      tick = 1'b0;
      chk("ticks_state", 32'(dut.state), 32'(ST_PLAY));
      chk("ticks_fx", 32'(fruit_x), 32'(keep_x));
      chk("ticks_fy", 32'(fruit_y), 32'(keep_y));
      chk("ticks_fv", 32'(fruit_valid), 32'd1);
`endif

      // burn lives down to 1
      for (int i = 0; i < 5; i++) begin
         hazard = 1'b1;
         step();
         hazard = 1'b0;
         chk("hz_lives", 32'(lives), 32'(5 - i));
      end
      step(); step();

      // hazard wins over a simultaneous collision on the last life
      hazard = 1'b1; collision = 1'b1; fct = FT_GROW;
      step();
      hazard = 1'b0; collision = 1'b0; fct = FT_NONE;
      chk("end_lives", 32'(lives), 32'd0);
      chk("end_go", 32'(game_over), 32'd1);
      chk("end_score", 32'(score), 32'd2);
      chk("end_fv", 32'(fruit_valid), 32'd0);
      chk("end_state", 32'(dut.state), 32'(ST_OVER));
      step();
      chk("end_grow", 32'(grow_pulse), 32'd0);

      // restart from OVER
      start = 1'b1;
      step();
      start = 1'b0;
      chk("rs_lives", 32'(lives), 32'd3);
      chk("rs_score", 32'(score), 32'd0);
      chk("rs_go", 32'(game_over), 32'd0);
      wait_valid("frs");
      start = 1'b1;
      step();
      start = 1'b0;
      chk("play_start_st", 32'(dut.state), 32'(ST_PLAY));
      chk("play_start_fv", 32'(fruit_valid), 32'd1);

      // reset mid-APPLY
      step();
      collision = 1'b1; fct = FT_GROW;
      step();
      collision = 1'b0; fct = FT_NONE;
      chk("ma_state", 32'(dut.state), 32'(ST_APPLY));
      reset = 1'b1;
      #1;
      chk("ma_async", 32'(dut.state), 32'(ST_IDLE));
      step();
      chk("ma_len", 32'(snake_len), 32'd0);
      chk("ma_score", 32'(score), 32'd0);
      chk("ma_grow", 32'(grow_pulse), 32'd0);
      chk("ma_fv", 32'(fruit_valid), 32'd0);
      reset = 1'b0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
